// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit producing a HI/LO pair.
// One shift-add or restoring-divide step per clock, with sign fix-up in a final cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     operand_q, operand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 signA_q, signA_d;
  logic                 signB_q, signB_d;
  logic [WIDTH-1:0]     srcaOrig_q, srcaOrig_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 inSigned;
  logic [WIDTH-1:0]     aMag, bMag;
  logic                 isDiv, isSigned;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH:0]     divShift;
  logic                 divFits;
  logic [WIDTH-1:0]     remSub;
  logic [2*WIDTH-1:0]   prodNeg;
  logic [WIDTH-1:0]     quotNeg, remNeg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      operand_q  <= '0;
      acc_q      <= '0;
      signA_q    <= 1'b0;
      signB_q    <= 1'b0;
      srcaOrig_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      signA_q    <= signA_d;
      signB_q    <= signB_d;
      srcaOrig_q <= srcaOrig_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  always_comb begin
    inSigned = ~op[0];
    aMag     = (inSigned && srca[WIDTH-1]) ? ({WIDTH{1'b0}} - srca) : srca;
    bMag     = (inSigned && srcb[WIDTH-1]) ? ({WIDTH{1'b0}} - srcb) : srcb;
    isDiv    = op_q[1];
    isSigned = ~op_q[0];

    // Multiply: the carry out of the upper add survives as the MSB after the right shift.
    mulSum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand_q})
                        : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    divShift = {acc_q, 1'b0};
    divFits  = divShift[2*WIDTH:WIDTH] >= {1'b0, operand_q};
    remSub   = WIDTH'(divShift[2*WIDTH:WIDTH] - {1'b0, operand_q});

    prodNeg  = {(2*WIDTH){1'b0}} - acc_q;
    quotNeg  = {WIDTH{1'b0}} - acc_q[WIDTH-1:0];
    remNeg   = {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH];

    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    signA_d    = signA_q;
    signB_d    = signB_q;
    srcaOrig_d = srcaOrig_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          cnt_d      = '0;
          operand_d  = op[1] ? bMag : aMag;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? aMag : bMag)};
          signA_d    = srca[WIDTH-1];
          signB_d    = srcb[WIDTH-1];
          srcaOrig_d = srca;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!isDiv) begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end else if (divFits) begin
          acc_d = {remSub, divShift[WIDTH-1:1], 1'b1};
        end else begin
          acc_d = divShift[2*WIDTH-1:0];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!isDiv) begin
          {hi_d, lo_d} = (isSigned && (signA_q ^ signB_q)) ? prodNeg : acc_q;
          dbz_d        = 1'b0;
        end else if (operand_q == '0) begin
          lo_d  = '1;
          hi_d  = srcaOrig_q;
          dbz_d = 1'b1;
        end else begin
          lo_d  = (isSigned && (signA_q ^ signB_q)) ? quotNeg : acc_q[WIDTH-1:0];
          hi_d  = (isSigned && signA_q) ? remNeg : acc_q[2*WIDTH-1:WIDTH];
          dbz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Launch one op, then wait for done; operands are scrambled after acceptance.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int latency, output int busyCycles);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); srca = $urandom; srcb = $urandom;
    busyCycles = busy ? 1 : 0;
    latency = 0;
    while (!done && latency < 100) begin
      @(posedge clk); #1;
      latency++;
      if (busy) busyCycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 0", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 0", lo); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int lat, bc;
    runOp(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    vectors++; if (bc !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    vectors++; if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL multu_done_one_cycle: got %b expected 0", done); end
    vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo_hold: got %h expected 00000001", lo); end
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    runOp(MULT, 32'hFFFFFFFD, 32'h00000007, lat, bc);
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo); end
    runOp(MULT, 32'h80000000, 32'h80000000, lat, bc);
    vectors++; if (hi !== 32'h40000000) begin miscompares++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
    vectors++; if (lo !== 32'h00000000) begin miscompares++; $display("FAIL mult_min_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_div();
    int lat, bc;
    runOp(DIV, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div_latency: got %0d expected 33", lat); end
    vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_signed_lo: got %h expected fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_signed_hi: got %h expected ffffffff", hi); end
    runOp(DIVU, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    vectors++; if (lo !== 32'h7FFFFFFC) begin miscompares++; $display("FAIL divu_lo: got %h expected 7ffffffc", lo); end
    vectors++; if (hi !== 32'h00000001) begin miscompares++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    runOp(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    vectors++; if (hi !== 32'h00000000) begin miscompares++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL div_ovf_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    runOp(DIVU, 32'd100, 32'd0, lat, bc);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL dbz_latency: got %0d expected 33", lat); end
    vectors++; if (lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
    vectors++; if (hi !== 32'h00000064) begin miscompares++; $display("FAIL dbz_hi: got %h expected 00000064", hi); end
    vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    runOp(MULTU, 32'd2, 32'd3, lat, bc);
    vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL dbz_next_lo: got %h expected 00000006", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL dbz_next_hi: got %h expected 00000000", hi); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_cleared: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; op = MULTU; srca = 32'd5; srcb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) begin start = 1'b1; op = MULTU; srca = 32'd9; srcb = 32'd9; end
      else start = 1'b0;
    end
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    vectors++; if (lo !== 32'd25) begin miscompares++; $display("FAIL ignore_lo: got %h expected 00000019", lo); end
    // Start presented in the done cycle must be taken on the very next edge.
    start = 1'b1; op = MULTU; srca = 32'd6; srcb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL b2b_lo: got %h expected 0000002a", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL b2b_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    logic sawDone;
    @(negedge clk);
    start = 1'b1; op = DIVU; srca = 32'd1000; srcb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    @(negedge clk); rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    vectors++; if (sawDone !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b expected 0", sawDone); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL abort_lo_after: got %h expected 00000000", lo); end
    runOp(DIVU, 32'd100, 32'd7, lat, bc);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 33", lat); end
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL post_reset_lo: got %h expected 0000000e", lo); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL post_reset_hi: got %h expected 00000002", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
